// File: rtl/led_strip_encoder.sv
// rtl/led_strip_encoder.sv - WS2812-style single-wire LED frame serialiser
module led_strip_encoder #(
    parameter int LED_COUNT          = 60,
    parameter int CLOCKS_PER_SEGMENT = 4,
    parameter int RESET_CLOCKS       = 960
) (
    input  logic        clock_12mhz,
    input  logic        reset,
    input  logic        framerate,
    output logic        pixel_request,
    output logic [9:0]  pixel_index,
    input  logic [23:0] pixel_data,
    input  logic        pixel_valid,
    output logic        led_data,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_skipped,
    output logic        underrun
);

    localparam int CW = $clog2(CLOCKS_PER_SEGMENT + 1);
    localparam int LW = $clog2(RESET_CLOCKS + 1);
    localparam logic [CW-1:0] SEG_LAST   = CW'(CLOCKS_PER_SEGMENT - 1);
    localparam logic [LW-1:0] LATCH_LAST = LW'(RESET_CLOCKS - 1);
    localparam logic [10:0]   PIXELS     = 11'(LED_COUNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          framerate_q;
    logic [CW-1:0] clk_count;
    logic [1:0]    seg_count;
    logic [4:0]    bit_count;
    logic [9:0]    pixel_count;
    logic [LW-1:0] latch_count;
    logic [23:0]   shift_reg;
    logic [23:0]   hold_reg;
    logic          hold_valid;

    logic start;
    logic accept;
    logic seg_end;
    logic bit_end;
    logic pixel_end;
    logic last_pixel;
    logic more_after_next;
    logic latch_end;

    assign start           = framerate & ~framerate_q;
    assign accept          = pixel_request & pixel_valid;
    assign seg_end         = (clk_count == SEG_LAST);
    assign bit_end         = seg_end && (seg_count == 2'd3);
    assign pixel_end       = bit_end && (bit_count == 5'd0);
    assign last_pixel      = ({1'b0, pixel_count} == (PIXELS - 11'd1));
    assign more_after_next = (({1'b0, pixel_count} + 11'd2) < PIXELS);
    assign latch_end       = (latch_count == LATCH_LAST);

    // State register
    always_ff @(posedge clock_12mhz or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus line, busy and end-of-frame decode
    always_comb begin
        state_next = state;
        led_data   = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (accept) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // Segment 0 is always high, segment 1 carries the bit value
                led_data = (seg_count == 2'd0) || ((seg_count == 2'd1) && shift_reg[23]);
                if (pixel_end && (last_pixel || !hold_valid)) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                if (latch_end) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Edge detect, pixel fetch/prefetch handshake, shift and timing counters
    always_ff @(posedge clock_12mhz or posedge reset) begin
        if (reset) begin
            framerate_q   <= 1'b0;
            frame_skipped <= 1'b0;
            underrun      <= 1'b0;
            pixel_request <= 1'b0;
            pixel_index   <= 10'd0;
            pixel_count   <= 10'd0;
            clk_count     <= '0;
            seg_count     <= 2'd0;
            bit_count     <= 5'd0;
            latch_count   <= '0;
            shift_reg     <= 24'd0;
            hold_reg      <= 24'd0;
            hold_valid    <= 1'b0;
        end else begin
            framerate_q   <= framerate;
            frame_skipped <= start && (state != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        pixel_request <= 1'b1;
                        pixel_index   <= 10'd0;
                        pixel_count   <= 10'd0;
                        hold_valid    <= 1'b0;
                    end
                end
                FETCH: begin
                    if (accept) begin
                        shift_reg <= pixel_data;
                        clk_count <= '0;
                        seg_count <= 2'd0;
                        bit_count <= 5'd23;
                        // Keep the request up and move straight on to the prefetch
                        if (PIXELS > 11'd1) begin
                            pixel_index <= 10'd1;
                        end else begin
                            pixel_request <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    if (accept) begin
                        hold_reg      <= pixel_data;
                        hold_valid    <= 1'b1;
                        pixel_request <= 1'b0;
                    end
                    if (seg_end) begin
                        clk_count <= '0;
                        seg_count <= seg_count + 2'd1;
                    end else begin
                        clk_count <= clk_count + CW'(1);
                    end
                    if (bit_end) begin
                        shift_reg <= {shift_reg[22:0], 1'b0};
                        bit_count <= bit_count - 5'd1;
                    end
                    if (pixel_end) begin
                        latch_count <= '0;
                        if (!last_pixel) begin
                            if (hold_valid) begin
                                shift_reg   <= hold_reg;
                                hold_valid  <= 1'b0;
                                bit_count   <= 5'd23;
                                pixel_count <= pixel_count + 10'd1;
                                if (more_after_next) begin
                                    pixel_request <= 1'b1;
                                    pixel_index   <= pixel_count + 10'd2;
                                end
                            end else begin
                                // Prefetch missed the boundary: truncate the frame
                                underrun      <= 1'b1;
                                pixel_request <= 1'b0;
                            end
                        end
                    end
                end
                LATCH: begin
                    latch_count   <= latch_count + LW'(1);
                    pixel_request <= 1'b0;
                end
                default: begin
                    pixel_request <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_strip_encoder.sv
// tb/tb_led_strip_encoder.sv - randomized self-checking bench for led_strip_encoder
module tb_led_strip_encoder;

    localparam int L       = 3;
    localparam int RC      = 960;
    localparam int PIX_CLK = 384;
    localparam int DEADLINE = 382;

    logic        clock_12mhz = 1'b0;
    logic        reset;
    logic        framerate;
    logic        pixel_request;
    logic [9:0]  pixel_index;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        led_data;
    logic        busy;
    logic        frame_done;
    logic        frame_skipped;
    logic        underrun;

    led_strip_encoder #(
        .LED_COUNT(L),
        .CLOCKS_PER_SEGMENT(4),
        .RESET_CLOCKS(RC)
    ) dut (
        .clock_12mhz(clock_12mhz),
        .reset(reset),
        .framerate(framerate),
        .pixel_request(pixel_request),
        .pixel_index(pixel_index),
        .pixel_data(pixel_data),
        .pixel_valid(pixel_valid),
        .led_data(led_data),
        .busy(busy),
        .frame_done(frame_done),
        .frame_skipped(frame_skipped),
        .underrun(underrun)
    );

    always #5 clock_12mhz = ~clock_12mhz;

    int cyc = 0;
    always @(posedge clock_12mhz) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    bit underrun_exp = 1'b0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Pixel source: per-index latency after the request is first seen
    logic [23:0] pix [L];
    int          lat [L];
    int          k0;
    int          req_seen [L];
    int          idx_q [$];

    initial begin
        int  cur;
        int  wcnt;
        bit  act;
        act = 1'b0;
        cur = 0;
        wcnt = 0;
        pixel_valid = 1'b0;
        pixel_data = 24'd0;
        forever begin
            @(negedge clock_12mhz);
            if (pixel_request === 1'b1) begin
                if (!act || int'(pixel_index) != cur) begin
                    act = 1'b1;
                    cur = int'(pixel_index);
                    wcnt = 0;
                    idx_q.push_back(cur);
                    if (cur < L) req_seen[cur] = cyc;
                end
                if (cur < L && wcnt >= lat[cur]) begin
                    pixel_valid = 1'b1;
                    pixel_data = pix[cur];
                    if (cur == 0) k0 = cyc;
                end else begin
                    pixel_valid = 1'b0;
                    pixel_data = 24'($urandom);
                end
                wcnt++;
            end else begin
                // Junk valid while nothing is requested must be ignored
                act = 1'b0;
                pixel_valid = 1'($urandom_range(0, 1));
                pixel_data = 24'($urandom);
            end
        end
    end

    // Output monitor
    logic led_q [$];
    int   done_q [$];
    int   skip_cnt;
    int   busy_fall;
    bit   rec = 1'b0;

    initial begin
        logic busy_d;
        busy_d = 1'b0;
        forever begin
            @(negedge clock_12mhz);
            if (rec) begin
                if (busy) led_q.push_back(led_data);
                if (frame_done) done_q.push_back(cyc);
                if (frame_skipped) skip_cnt++;
                if (busy_d && !busy) busy_fall = cyc;
            end
            busy_d = busy;
        end
    end

    task automatic rand_frame();
        for (int i = 0; i < L; i++) begin
            pix[i] = 24'($urandom);
            lat[i] = (i == 0) ? $urandom_range(0, 4) : $urandom_range(0, DEADLINE);
        end
    endtask

    task automatic run_frame(input bit do_skip);
        int   t0;
        int   m;
        int   n_exp;
        int   mis;
        int   bad;
        int   guard;
        int   done_exp;
        logic exp_q [$];
        led_q.delete();
        done_q.delete();
        idx_q.delete();
        skip_cnt = 0;
        busy_fall = -1;
        k0 = -1;
        for (int i = 0; i < L; i++) req_seen[i] = -1;
        rec = 1'b1;
        @(negedge clock_12mhz); #1;
        framerate = 1'b1;
        t0 = cyc;
        @(negedge clock_12mhz); #1;
        check("start_busy", busy, 1);
        check("start_request", pixel_request, 1);
        check("start_index", pixel_index, 0);
        guard = 0;
        while (busy_fall < 0 && guard < 30000) begin
            @(negedge clock_12mhz); #1;
            guard++;
            if (cyc == t0 + 40) framerate = 1'b0;
            if (do_skip && k0 >= 0 && cyc == k0 + 500) framerate = 1'b1;
            if (do_skip && k0 >= 0 && cyc == k0 + 510) framerate = 1'b0;
        end
        rec = 1'b0;
        framerate = 1'b0;
        check("frame_end_seen", busy_fall >= 0, 1);

        // Reference: a pixel n>0 makes it only if delivered within 383 clocks of its request
        m = L;
        for (int n = 1; n < L; n++) begin
            if (lat[n] > DEADLINE) begin
                m = n;
                break;
            end
        end
        if (m < L) underrun_exp = 1'b1;
        for (int i = 0; i < k0 - t0; i++) exp_q.push_back(1'b0);
        for (int p = 0; p < m; p++) begin
            for (int b = 23; b >= 0; b--) begin
                int hi;
                hi = pix[p][b] ? 8 : 4;
                for (int c = 0; c < 16; c++) exp_q.push_back(c < hi);
            end
        end
        for (int i = 0; i < RC; i++) exp_q.push_back(1'b0);
        done_exp = k0 + PIX_CLK * m + RC;

        check("wave_length", led_q.size(), exp_q.size());
        mis = 0;
        for (int i = 0; i < exp_q.size() && i < led_q.size(); i++) begin
            if (led_q[i] !== exp_q[i]) mis++;
        end
        check("wave_bits", mis, 0);
        check("done_pulses", done_q.size(), 1);
        if (done_q.size() > 0) check("done_cycle", done_q[0], done_exp);
        check("busy_fall_cycle", busy_fall, done_exp + 1);

        n_exp = (m < L) ? m + 1 : L;
        check("index_count", idx_q.size(), n_exp);
        bad = 0;
        for (int j = 0; j < idx_q.size(); j++) if (idx_q[j] != j) bad++;
        if (req_seen[0] != t0 + 1) bad++;
        for (int j = 1; j < n_exp; j++) begin
            if (req_seen[j] != k0 + 1 + PIX_CLK * (j - 1)) bad++;
        end
        check("index_sequence", bad, 0);
        check("skipped_pulses", skip_cnt, do_skip ? 1 : 0);
        check("underrun_flag", underrun, underrun_exp);
        check("request_idle", pixel_request, 0);
    endtask

    task automatic reset_mid_frame();
        int guard;
        int target;
        for (int i = 0; i < L; i++) begin
            pix[i] = 24'hFFFFFF;
            lat[i] = 0;
        end
        lat[0] = 2;
        k0 = -1;
        @(negedge clock_12mhz); #1;
        framerate = 1'b1;
        guard = 0;
        while (k0 < 0 && guard < 50) begin
            @(negedge clock_12mhz); #1;
            guard++;
            if (guard == 10) framerate = 1'b0;
        end
        framerate = 1'b0;
        check("reset_test_fetch", k0 >= 0, 1);
        // Third clock of bit 5 (the 19th bit sent)
        target = k0 + 1 + 18 * 16 + 2;
        guard = 0;
        while (cyc < target && guard < 2000) begin
            @(negedge clock_12mhz);
            guard++;
        end
        #1;
        check("pre_reset_led", led_data, 1);
        reset = 1'b1;
        #1;
        check("reset_led", led_data, 0);
        check("reset_request", pixel_request, 0);
        check("reset_busy", busy, 0);
        check("reset_underrun", underrun, 0);
        underrun_exp = 1'b0;
        repeat (3) @(negedge clock_12mhz);
        reset = 1'b0;
        repeat (3) @(negedge clock_12mhz);
        check("after_reset_led", led_data, 0);
        check("after_reset_busy", busy, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        framerate = 1'b0;
        for (int i = 0; i < L; i++) begin
            pix[i] = 24'd0;
            lat[i] = 0;
            req_seen[i] = -1;
        end
        repeat (3) @(negedge clock_12mhz);
        #1;
        check("rst_led", led_data, 0);
        check("rst_busy", busy, 0);
        check("rst_request", pixel_request, 0);
        check("rst_index", pixel_index, 0);
        check("rst_done", frame_done, 0);
        check("rst_skipped", frame_skipped, 0);
        check("rst_underrun", underrun, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock_12mhz);

        // Back-to-back pixels
        pix[0] = 24'h000001; pix[1] = 24'h800000; pix[2] = 24'hAAAAAA;
        lat[0] = 1; lat[1] = 0; lat[2] = 5;
        run_frame(1'b0);

        // Slow first fetch
        rand_frame();
        lat[0] = 100;
        run_frame(1'b0);

        // Prefetch delivered on the last allowed clock
        rand_frame();
        lat[1] = DEADLINE;
        lat[2] = DEADLINE;
        run_frame(1'b0);

        // Frame edge while busy
        rand_frame();
        run_frame(1'b1);

        // Underrun on pixel 1, one clock past the deadline
        rand_frame();
        lat[1] = DEADLINE + 1;
        run_frame(1'b0);

        // Underrun on pixel 2 with a clean frame after: flag stays set
        rand_frame();
        lat[2] = DEADLINE + 1 + $urandom_range(0, 20);
        run_frame(1'b0);
        rand_frame();
        run_frame(1'b0);

        // Reset mid-frame, then restart from index 0
        reset_mid_frame();
        for (int r = 0; r < 3; r++) begin
            rand_frame();
            run_frame(1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
